rr_arbiter_stage: RTL and testbench

Round-robin arbitration stage that chooses one of ENTRIES valid/ready sources per cycle and registers the winner's payload into a single output register. It sits directly upstream of the one-hot `parameterized_mux` consumers. It produces the one-hot grant that drives the data selection (`parameterized_mux` with ONEHOT=1), and it exports the registered grant in both one-hot and binary form for downstream stages. Throughput is one transfer per cycle and latency is one cycle.

---
 rtl/rr_arbiter_pkg.sv | 22 ++
 rtl/parameterized_mux.sv | 21 ++
 rtl/rr_grant.sv | 20 ++
 rtl/rr_arbiter_stage.sv | 56 +++++
 tb/tb_rr_arbiter_stage.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_pkg.sv
// rr_arbiter_pkg: shared sizing and one-hot helpers for the round-robin arbiter stage.
package rr_arbiter_pkg;
  localparam int MAX_ENTRIES = 32;
  localparam int MAX_INDEX = $clog2(MAX_ENTRIES);
  // Callers pass their own ENTRIES as n; vectors are zero-extended to MAX_ENTRIES.
  function automatic logic [MAX_ENTRIES-1:0] rr_pick(input logic [MAX_ENTRIES-1:0] req, input int last, input int n);
    logic found;
    rr_pick = '0;
    found = 1'b0;
    for (int i = 1; i <= n; i++) begin
      if (!found && req[MAX_INDEX'((last + i) % n)]) begin
        rr_pick[MAX_INDEX'((last + i) % n)] = 1'b1;
        found = 1'b1;
      end
    end
  endfunction
  function automatic logic [MAX_INDEX-1:0] onehot_to_index(input logic [MAX_ENTRIES-1:0] oh);
    onehot_to_index = '0;
    for (int k = 0; k < MAX_ENTRIES; k++)
      if (oh[k]) onehot_to_index = onehot_to_index | MAX_INDEX'(k);
  endfunction
endpackage

// File: rtl/parameterized_mux.sv
// parameterized_mux: N-way payload select with one-hot or binary select.
module parameterized_mux #(
  parameter type DATA = logic [7:0],
  parameter int ENTRIES = 4,
  parameter bit ONEHOT = 1'b1,
  parameter int SEL = ONEHOT ? ENTRIES : ((ENTRIES > 1) ? $clog2(ENTRIES) : 1)
) (
  input  logic [SEL-1:0]     sel,
  input  DATA [ENTRIES-1:0]  data,
  output DATA                y
);
  if (ONEHOT) begin : g_onehot
    always_comb begin
      y = '0;
      for (int k = 0; k < ENTRIES; k++)
        if (sel[k]) y = y | data[k];
    end
  end else begin : g_binary
    assign y = data[sel];
  end
endmodule

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin pick (rotate past last, lowest-set-bit, unrotate).
module rr_grant #(
  parameter int ENTRIES = 4,
  parameter int INDEX_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic [ENTRIES-1:0]     req,
  input  logic [INDEX_WIDTH-1:0] last,
  output logic [ENTRIES-1:0]     grant
);
  logic [ENTRIES-1:0] rot, pick;
  always_comb begin
    rot = '0;
    grant = '0;
    for (int j = 0; j < ENTRIES; j++)
      rot[j] = req[INDEX_WIDTH'((int'(last) + 1 + j) % ENTRIES)];
    pick = rot & (~rot + ENTRIES'(1));
    for (int j = 0; j < ENTRIES; j++)
      grant[INDEX_WIDTH'((int'(last) + 1 + j) % ENTRIES)] = pick[j];
  end
endmodule

// File: rtl/rr_arbiter_stage.sv
// rr_arbiter_stage: round-robin select of ENTRIES valid/ready sources into one output register.
module rr_arbiter_stage
  import rr_arbiter_pkg::*;
#(
  parameter type DATA = logic [7:0],
  parameter int ENTRIES = 4,
  parameter int INDEX_WIDTH = (ENTRIES > 1) ? $clog2(ENTRIES) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [ENTRIES-1:0]     i_valid,
  output logic [ENTRIES-1:0]     o_ready,
  input  DATA [ENTRIES-1:0]      i_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output DATA                    o_data,
  output logic [ENTRIES-1:0]     o_grant,
  output logic [INDEX_WIDTH-1:0] o_grant_index
);
  logic load, xfer;
  logic [ENTRIES-1:0] grant;
  logic [INDEX_WIDTH-1:0] last, grant_index;
  DATA sel_data;
  rr_grant #(.ENTRIES(ENTRIES), .INDEX_WIDTH(INDEX_WIDTH)) u_grant (
    .req(i_valid),
    .last(last),
    .grant(grant)
  );
  parameterized_mux #(DATA, ENTRIES, 1) u_mux (
    .sel(grant),
    .data(i_data),
    .y(sel_data)
  );
  assign load = !o_valid || i_ready;
  // Reset gating keeps o_ready low even while o_valid is still unknown.
  assign o_ready = (load && !i_rst) ? grant : '0;
  assign xfer = |o_ready;
  assign grant_index = INDEX_WIDTH'(onehot_to_index(MAX_ENTRIES'(grant)));
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data <= '0;
      o_grant <= '0;
      o_grant_index <= '0;
      last <= INDEX_WIDTH'(ENTRIES - 1);
    end else if (load) begin
      o_valid <= xfer;
      if (xfer) begin
        o_data <= sel_data;
        o_grant <= grant;
        o_grant_index <= grant_index;
        last <= grant_index;
      end
    end
  end
endmodule

// File: tb/tb_rr_arbiter_stage.sv
// tb_rr_arbiter_stage: scoreboard bench for the 4-entry and 1-entry arbiter stage.
module tb_rr_arbiter_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_ready, out_valid;
  logic [3:0] valid, ready, grant;
  logic [3:0][7:0] in_data;
  logic [7:0] out_data;
  logic [1:0] gidx;
  logic v1, rdy1, ov1;
  logic [0:0] r1, g1, gi1;
  logic [0:0][7:0] d1;
  logic [7:0] od1;
  typedef struct packed {logic [7:0] d; logic [3:0] g; logic [1:0] i;} item_t;
  item_t q[$];
  item_t cur;
  logic [7:0] q1[$];
  logic [7:0] cur1;
  int m_last, checks, fails;
  bit m_valid, m1_valid, m1_seen;
  rr_arbiter_stage #(.DATA(logic [7:0]), .ENTRIES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready), .i_data(in_data),
    .o_valid(out_valid), .i_ready(in_ready), .o_data(out_data), .o_grant(grant), .o_grant_index(gidx)
  );
  rr_arbiter_stage #(.DATA(logic [7:0]), .ENTRIES(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1), .i_data(d1),
    .o_valid(ov1), .i_ready(rdy1), .o_data(od1), .o_grant(g1), .o_grant_index(gi1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] model_pick(input logic [3:0] v, input int last);
    for (int i = 1; i <= 4; i++)
      if (v[(last + i) % 4]) return 4'(1 << ((last + i) % 4));
    return 4'b0;
  endfunction
  task automatic step();
    logic [3:0] er;
    int k;
    #1;
    er = (!rst && (!m_valid || in_ready)) ? model_pick(valid, m_last) : 4'b0;
    chk("o_ready", 32'(ready), 32'(er));
    k = -1;
    for (int i = 0; i < 4; i++) if (er[i]) k = i;
    if (k >= 0) q.push_back('{in_data[k], er, 2'(k)});
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 1'b0;
      m_last = 3;
      q.delete();
      cur = '0;
    end else if (!m_valid || in_ready) begin
      m_valid = (k >= 0);
      if (k >= 0) begin
        m_last = k;
        cur = q.pop_front();
      end
    end
    chk("o_valid", 32'(out_valid), 32'(m_valid));
    chk("o_data", 32'(out_data), 32'(cur.d));
    chk("o_grant", 32'(grant), 32'(cur.g));
    chk("o_grant_index", 32'(gidx), 32'(cur.i));
  endtask
  task automatic step1();
    logic er;
    #1;
    er = (!m1_valid || rdy1) && v1;
    chk("o_ready1", 32'(r1), 32'(er));
    if (er) q1.push_back(d1[0]);
    @(posedge clk);
    #1;
    if (!m1_valid || rdy1) begin
      m1_valid = er;
      if (er) begin
        cur1 = q1.pop_front();
        m1_seen = 1'b1;
      end
    end
    chk("o_valid1", 32'(ov1), 32'(m1_valid));
    chk("o_data1", 32'(od1), 32'(cur1));
    chk("o_grant1", 32'(g1), 32'(m1_seen));
    chk("o_grant_index1", 32'(gi1), 32'd0);
    if (er) d1[0] = d1[0] + 8'd1;
  endtask
  initial begin
    checks = 0;
    fails = 0;
    m_last = 3;
    m_valid = 1'b0;
    cur = '0;
    m1_valid = 1'b0;
    m1_seen = 1'b0;
    cur1 = '0;
    rst = 1'b1;
    valid = '0;
    in_ready = 1'b1;
    in_data = '0;
    v1 = 1'b0;
    rdy1 = 1'b1;
    d1 = '0;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    in_data = {8'h33, 8'h22, 8'h11, 8'h00};
    valid = 4'hF;
    repeat (5) step();
    valid = 4'b1010;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    valid = 4'hF;
    repeat (3) step();
    chk("held_22", 32'(out_data), 32'h22);
    in_ready = 1'b0;
    repeat (3) step();
    in_ready = 1'b1;
    step();
    chk("resume_grant", 32'(grant), 32'b1000);
    repeat (3) step();
    chk("last_is_2", 32'(gidx), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("post_reset_grant", 32'(grant), 32'b0001);
    repeat (300) begin
      valid = 4'($urandom);
      in_ready = 1'($urandom);
      in_data = 32'($urandom);
      step();
    end
    valid = '0;
    in_ready = 1'b1;
    d1[0] = 8'hA0;
    v1 = 1'b1;
    repeat (4) begin
      rdy1 = 1'b1;
      step1();
      rdy1 = 1'b0;
      step1();
      rdy1 = 1'b1;
      step1();
    end
    v1 = 1'b0;
    repeat (2) step1();
    chk("stream_drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
